// File: rtl/decode_stage_pkg.sv
// Shared opcode/field definitions and the decoded-control bundle for the ID stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decode_stage_pkg;

    localparam int INSTR_W = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    // Everything the decoder derives from one instruction word
    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [5:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic        uses_rs;
        logic        uses_rt;
    } ctrl_t;

    function automatic logic [4:0] get_rs(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] get_rt(input logic [INSTR_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Register-bank read port plus snooped writeback port, as seen by the decode stage.
// Latency: bank read data is registered, valid one edge after the address.
// Backpressure: none; the bank always accepts a read address.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] addra;
    logic [REG_AW-1:0] addrb;
    logic [DATA_W-1:0] dataa;
    logic [DATA_W-1:0] datab;
    logic              enc;
    logic [REG_AW-1:0] addrc;
    logic [DATA_W-1:0] datac;

    // Decode stage side
    modport master (
        output addra, addrb,
        input  dataa, datab, enc, addrc, datac
    );

    // Register bank / writeback side
    modport slave (
        input  addra, addrb,
        output dataa, datab, enc, addrc, datac
    );
endinterface

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: control flags, extended immediate, destination, operand use.
// Latency: zero (pure combinational).
// Backpressure: none.
module decode_ctrl
    import decode_stage_pkg::*;
#(
    parameter int LINK_REG = 31
) (
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign op    = instr[OP_MSB:OP_LSB];
    assign funct = instr[FN_MSB:FN_LSB];
    assign rt    = instr[RT_MSB:RT_LSB];
    assign rd    = instr[RD_MSB:RD_LSB];
    assign imm16 = instr[IMM_MSB:IMM_LSB];

    // Decode the opcode into the control bundle; unknown opcodes become an illegal NOP
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = op;
        ctrl.shamt  = instr[SH_MSB:SH_LSB];
        ctrl.imm    = {{16{imm16[15]}}, imm16};
        case (op)
            OP_RTYPE: begin
                ctrl.alu_op    = funct;
                ctrl.dest      = rd;
                ctrl.reg_write = (funct != FUNCT_JR);
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OP_LW: begin
                ctrl.dest      = rt;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                ctrl.dest      = rt;
                ctrl.reg_write = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.imm       = {16'h0000, imm16};
                ctrl.dest      = rt;
                ctrl.reg_write = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OP_LUI: begin
                ctrl.imm       = {imm16, 16'h0000};
                ctrl.dest      = rt;
                ctrl.reg_write = 1'b1;
            end
            OP_J: begin
                ctrl.imm       = {6'b0, instr[TGT_MSB:TGT_LSB]};
                ctrl.jump      = 1'b1;
            end
            OP_JAL: begin
                ctrl.imm       = {6'b0, instr[TGT_MSB:TGT_LSB]};
                ctrl.jump      = 1'b1;
                ctrl.dest      = 5'(LINK_REG);
                ctrl.reg_write = 1'b1;
            end
            default: begin
                ctrl.illegal   = 1'b1;
            end
        endcase
        // r0 is hardwired, so a write to it is never a real write
        if (ctrl.dest == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// IF/ID register + decoder: drives bank read addresses, bypasses same-edge writeback, interlocks load-use.
// Latency: one edge from fetch word to id_issue; a load-use hazard adds exactly one bubble.
// Backpressure: stall_out holds fetch for one cycle on load-use; flush overrides and empties the slot.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              valid_in,
    input  logic              flush,
    output logic              stall_out,
    decode_stage_if.master    bank,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    output logic              id_issue,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_opa,
    output logic [DATA_W-1:0] id_opb,
    output logic [DATA_W-1:0] id_imm,
    output logic [REG_AW-1:0] id_dest,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_alu_op,
    output logic              id_reg_write,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_branch,
    output logic              id_jump,
    output logic              id_illegal
);

    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc_q;
    logic              byp_a_v;
    logic              byp_b_v;
    logic [DATA_W-1:0] byp_a;
    logic [DATA_W-1:0] byp_b;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic              hz;
    ctrl_t             ctrl;

    decode_ctrl #(
        .LINK_REG (LINK_REG)
    ) u_ctrl (
        .instr (instr_q),
        .ctrl  (ctrl)
    );

    assign rs_q = get_rs(instr_q);
    assign rt_q = get_rt(instr_q);

    // Load in EX whose result this instruction needs: not available until after the load leaves EX
    assign hz = valid_q && ex_mem_read && (ex_dest != '0) &&
                ((ctrl.uses_rs && (ex_dest == rs_q)) || (ctrl.uses_rt && (ex_dest == rt_q)));

    assign stall_out = hz && !flush;

    // While stalled, keep re-reading the held instruction so late writebacks are picked up
    assign bank.addra = stall_out ? rs_q : get_rs(instr_in);
    assign bank.addrb = stall_out ? rt_q : get_rt(instr_in);

    // IF/ID register: flush empties the slot, stall holds it, otherwise take the fetch word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall_out) begin
            valid_q <= valid_in;
            instr_q <= instr_in;
            pc_q    <= pc_in;
        end
    end

    // Capture a writeback that lands on the same edge as the read; the bank returns the old value then
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byp_a_v <= 1'b0;
            byp_b_v <= 1'b0;
            byp_a   <= '0;
            byp_b   <= '0;
        end else begin
            byp_a_v <= bank.enc && (bank.addrc == bank.addra) && (bank.addrc != '0);
            byp_b_v <= bank.enc && (bank.addrc == bank.addrb) && (bank.addrc != '0);
            byp_a   <= bank.datac;
            byp_b   <= bank.datac;
        end
    end

    assign id_issue     = valid_q && !hz;
    assign id_pc        = pc_q;
    assign id_opa       = (rs_q == 5'd0) ? '0 : (byp_a_v ? byp_a : bank.dataa);
    assign id_opb       = (rt_q == 5'd0) ? '0 : (byp_b_v ? byp_b : bank.datab);
    assign id_imm       = ctrl.imm;
    assign id_dest      = ctrl.dest;
    assign id_shamt     = ctrl.shamt;
    assign id_alu_op    = ctrl.alu_op;
    assign id_reg_write = ctrl.reg_write;
    assign id_mem_read  = ctrl.mem_read;
    assign id_mem_write = ctrl.mem_write;
    assign id_branch    = ctrl.branch;
    assign id_jump      = ctrl.jump;
    assign id_illegal   = ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage with a registered register-bank model and an issue scoreboard.
// Latency: expectations are queued on fetch acceptance and compared when id_issue is seen.
// Backpressure: stall_out is honoured by holding the fetch word.
module tb_decode_stage;

    localparam logic [5:0] F_RW = 6'b000001;
    localparam logic [5:0] F_MR = 6'b000010;
    localparam logic [5:0] F_MW = 6'b000100;
    localparam logic [5:0] F_BR = 6'b001000;
    localparam logic [5:0] F_JP = 6'b010000;
    localparam logic [5:0] F_IL = 6'b100000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr_in, pc_in;
    logic        valid_in, flush, stall_out, ex_mem_read;
    logic [4:0]  ex_dest;
    logic        id_issue;
    logic [31:0] id_pc, id_opa, id_opb, id_imm;
    logic [4:0]  id_dest, id_shamt;
    logic [5:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;
    logic [5:0]  dut_flags;

    decode_stage_if bank ();

    decode_stage dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .valid_in(valid_in), .flush(flush), .stall_out(stall_out), .bank(bank),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .id_issue(id_issue),
        .id_pc(id_pc), .id_opa(id_opa), .id_opb(id_opb), .id_imm(id_imm),
        .id_dest(id_dest), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jump(id_jump),
        .id_illegal(id_illegal)
    );

    always #5 clock = ~clock;

    assign dut_flags = {id_illegal, id_jump, id_branch, id_mem_write, id_mem_read, id_reg_write};

    typedef struct {
        logic [31:0] pc, opa, opb, imm;
        logic [4:0]  dest, shamt;
        logic [5:0]  alu, flags;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] sh [32];
    logic [31:0] rf [32];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] p_imm, next_pc;
    logic [4:0]  p_dest;
    logic [5:0]  p_alu, p_flags;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h0000_1234;
            1:       return 32'd7;
            3:       return 32'h0000_0033;
            5:       return 32'd11;
            default: return 32'd0;
        endcase
    endfunction

    // Register bank: registered reads return the pre-write value on a same-edge write
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else begin
            bank.dataa <= rf[bank.addra];
            bank.datab <= rf[bank.addrb];
            if (bank.enc) rf[bank.addrc] <= bank.datac;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [31:0] ins, input logic [31:0] imm, input logic [4:0] dest,
                       input logic [5:0] alu, input logic [5:0] flags);
        instr_in = ins;
        pc_in    = next_pc;
        valid_in = 1'b1;
        p_imm    = imm;
        p_dest   = dest;
        p_alu    = alu;
        p_flags  = flags;
    endtask

    // Called once per cycle with inputs settled: retire issues, apply writeback, queue acceptances, advance
    task automatic cyc();
        exp_t        e;
        logic [31:0] ins;
        if (id_issue) begin
            chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("pc",    id_pc,            e.pc);
                chk("opa",   id_opa,           e.opa);
                chk("opb",   id_opb,           e.opb);
                chk("imm",   id_imm,           e.imm);
                chk("dest",  32'(id_dest),     32'(e.dest));
                chk("shamt", 32'(id_shamt),    32'(e.shamt));
                chk("alu",   32'(id_alu_op),   32'(e.alu));
                chk("flags", 32'(dut_flags),   32'(e.flags));
            end
        end
        if (flush && !id_issue && sbq.size() != 0) void'(sbq.pop_front());
        if (bank.enc && bank.addrc != 5'd0) sh[bank.addrc] = bank.datac;
        if (valid_in && !stall_out && !flush) begin
            ins     = instr_in;
            e.pc    = pc_in;
            e.opa   = (ins[25:21] == 5'd0) ? 32'd0 : sh[ins[25:21]];
            e.opb   = (ins[20:16] == 5'd0) ? 32'd0 : sh[ins[20:16]];
            e.imm   = p_imm;
            e.dest  = p_dest;
            e.shamt = ins[10:6];
            e.alu   = p_alu;
            e.flags = p_flags;
            sbq.push_back(e);
            next_pc = next_pc + 32'd4;
        end
        @(posedge clock);
        #1;
    endtask

    logic [31:0] t_ins [9] = '{32'hFC22_1234, 32'h0C00_0010, 32'h302B_8000, 32'hAC25_0004,
                               32'h8C2C_FFFC, 32'h0020_0008, 32'h0025_0020, 32'h0001_6900,
                               32'h1465_0008};
    logic [31:0] t_imm [9] = '{32'h0000_1234, 32'h0000_0010, 32'h0000_8000, 32'h0000_0004,
                               32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0020, 32'h0000_6900,
                               32'h0000_0008};
    logic [4:0]  t_dst [9] = '{5'd0, 5'd31, 5'd11, 5'd0, 5'd12, 5'd0, 5'd0, 5'd13, 5'd0};
    logic [5:0]  t_alu [9] = '{6'h3F, 6'h03, 6'h0C, 6'h2B, 6'h23, 6'h08, 6'h20, 6'h00, 6'h05};
    logic [5:0]  t_flg [9] = '{F_IL, F_JP | F_RW, F_RW, F_MW, F_RW | F_MR, 6'b0, 6'b0, F_RW, F_BR};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; instr_in = '0; pc_in = '0; valid_in = 1'b0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_dest = '0;
        bank.enc = 1'b0; bank.addrc = '0; bank.datac = '0;
        next_pc = 32'h0000_0100;
        for (int i = 0; i < 32; i++) sh[i] = init_val(i);
        #1 reset = 1'b0;
        #2;
        chk("rst_stall", 32'(stall_out),  32'd0);
        chk("rst_issue", 32'(id_issue),   32'd0);
        chk("rst_pc",    id_pc,           32'd0);
        chk("rst_opa",   id_opa,          32'd0);
        chk("rst_imm",   id_imm,          32'd0);
        chk("rst_dest",  32'(id_dest),    32'd0);
        chk("rst_alu",   32'(id_alu_op),  32'd0);
        chk("rst_flags", 32'(dut_flags),  32'd0);
        #9 reset = 1'b1;
        @(posedge clock); #1;

        // addi r2,r1,5 with r1=7
        drv(32'h2022_0005, 32'd5, 5'd2, 6'h08, F_RW); #1; cyc();
        valid_in = 1'b0; #1;
        chk("addi_issue", 32'(id_issue), 32'd1);
        chk("addi_opa",   id_opa,        32'd7);
        cyc();

        // add r4,r3,r5 behind a lw r3 in EX: one bubble, fetch word held
        drv(32'h0065_2020, 32'h0000_2020, 5'd4, 6'h20, F_RW); #1; cyc();
        drv(32'h3407_00FF, 32'h0000_00FF, 5'd7, 6'h0D, F_RW);
        ex_mem_read = 1'b1; ex_dest = 5'd3; #1;
        chk("hz_stall", 32'(stall_out),   32'd1);
        chk("hz_issue", 32'(id_issue),    32'd0);
        chk("hz_addra", 32'(bank.addra),  32'd3);
        chk("hz_addrb", 32'(bank.addrb),  32'd5);
        cyc();
        ex_mem_read = 1'b0; ex_dest = 5'd0; #1;
        chk("hz_release", 32'(stall_out), 32'd0);
        chk("hz_issue2",  32'(id_issue),  32'd1);
        cyc();
        valid_in = 1'b0; #1;
        chk("ori_issue", 32'(id_issue), 32'd1);
        cyc();

        // addiu r8,r6,1 loaded on the same edge as writeback r6=DEADBEEF
        drv(32'h24C8_0001, 32'd1, 5'd8, 6'h09, F_RW);
        bank.enc = 1'b1; bank.addrc = 5'd6; bank.datac = 32'hDEAD_BEEF; #1; cyc();
        valid_in = 1'b0; bank.enc = 1'b0; #1;
        chk("byp_opa", id_opa, 32'hDEAD_BEEF);
        cyc();

        // addi r9,r0,3 while bank holds 0x1234 in r0 and writeback targets r0
        drv(32'h2009_0003, 32'd3, 5'd9, 6'h08, F_RW);
        bank.enc = 1'b1; bank.addrc = 5'd0; bank.datac = 32'h0000_5555; #1; cyc();
        valid_in = 1'b0; bank.enc = 1'b0; #1;
        chk("r0_opa", id_opa, 32'd0);
        cyc();

        // beq r3,r5 hits a load-use on rt, flushed in the same cycle
        drv(32'h1065_0004, 32'd4, 5'd0, 6'h04, F_BR); #1; cyc();
        drv(32'hFC00_0000, 32'd0, 5'd0, 6'h3F, F_IL);
        ex_mem_read = 1'b1; ex_dest = 5'd5; flush = 1'b1; #1;
        chk("fl_stall", 32'(stall_out), 32'd0);
        chk("fl_issue", 32'(id_issue),  32'd0);
        cyc();
        flush = 1'b0; ex_mem_read = 1'b0; ex_dest = 5'd0;
        drv(32'h3C0A_ABCD, 32'hABCD_0000, 5'd10, 6'h0F, F_RW); #1;
        chk("fl_empty", 32'(id_issue), 32'd0);
        cyc();
        valid_in = 1'b0; #1;
        chk("lui_issue", 32'(id_issue), 32'd1);
        cyc();

        // Back-to-back decode table
        for (int i = 0; i < 9; i++) begin
            drv(t_ins[i], t_imm[i], t_dst[i], t_alu[i], t_flg[i]); #1; cyc();
        end
        valid_in = 1'b0; #1; cyc();
        chk("sb_drain", 32'(sbq.size()), 32'd0);

        // Reset asserted in the middle of a stall
        drv(32'h0065_2020, 32'h0000_2020, 5'd4, 6'h20, F_RW); #1; cyc();
        valid_in = 1'b0; ex_mem_read = 1'b1; ex_dest = 5'd3; #1;
        chk("rs_pre_stall", 32'(stall_out), 32'd1);
        reset = 1'b0; #1;
        chk("rs_stall", 32'(stall_out), 32'd0);
        chk("rs_issue", 32'(id_issue),  32'd0);
        chk("rs_pc",    id_pc,          32'd0);
        sbq.delete();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID pipeline register and instruction decoder. Sits between fetch and the register bank.
- Drives the bank's read addresses and captures the bank's registered read data.
- Interlocks load-use hazards with the execute stage.
- Bypasses same-edge writeback, because the bank returns the old value when a read and a write hit the same edge.

Parameters:
- DATA_W, 32, datapath and instruction width.
- REG_AW, 5, register address width.
- LINK_REG, 31, destination register of jal.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- instr_in  in  32  instruction from fetch.
- pc_in  in  32  PC of instr_in.
- valid_in  in  1  instr_in is valid.
- flush  in  1  branch/jump resolved taken; kill the ID slot.
- stall_out  out  1  to fetch: hold instr_in/pc_in.
- addra  out  5  bank read address A.
- addrb  out  5  bank read address B.
- dataa  in  32  bank registered read data A.
- datab  in  32  bank registered read data B.
- enc  in  1  writeback enable (snooped).
- addrc  in  5  writeback address (snooped).
- datac  in  32  writeback data (snooped).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_dest  in  5  destination register of the instruction in EX.
- id_issue  out  1  ID bundle valid to EX this cycle.
- id_pc  out  32  PC of the issued instruction.
- id_opa  out  32  rs operand.
- id_opb  out  32  rt operand.
- id_imm  out  32  extended immediate.
- id_dest  out  5  destination register.
- id_shamt  out  5  shift amount.
- id_alu_op  out  6  funct for R-type, opcode otherwise.
- id_reg_write  out  1  instruction writes a register.
- id_mem_read  out  1  instruction is a load.
- id_mem_write  out  1  instruction is a store.
- id_branch  out  1  beq/bne.
- id_jump  out  1  j/jal.
- id_illegal  out  1  unknown opcode; executes as NOP.

Behaviour:
- Reset (reset=0, async): ID register valid=0; instr=0; pc=0; bypass flags=0. All outputs 0, stall_out=0.
- ID register update on rising edge, in priority order:
  - flush → valid<=0.
  - stall_out → hold.
  - otherwise load instr_in/pc_in and valid<=valid_in.
- Address drive (combinational):
  - stall_out=0 → addra=instr_in[25:21], addrb=instr_in[20:16].
  - stall_out=1 → same fields taken from the held instr.
  - Result: dataa/datab always correspond to the held instruction one edge later.
- Write bypass, port A (B symmetric):
  - At each edge: byp_a_v <= enc && addrc==addra && addrc!=0; byp_a <= datac.
  - id_opa = (rs==0) ? 0 : byp_a_v ? byp_a : dataa.
- Load-use hazard:
  - hz = valid && ex_mem_read && ex_dest!=0 && ((uses_rs && ex_dest==rs) || (uses_rt && ex_dest==rt)).
  - stall_out = hz && !flush.
  - id_issue = valid && !hz. The bubble is seen by EX as id_issue=0.
  - The hazard lasts exactly one cycle, because the load leaves EX.
  - The re-read during the stall picks up any writeback through the bypass.
- Decode:
  - R-type (0x00): dest=rd; reg_write unless funct=0x08 (jr); uses rs, rt.
  - lw 0x23: dest=rt, mem_read, uses rs.
  - sw 0x2B: mem_write, no reg_write, uses rs, rt.
  - beq 0x04 / bne 0x05: branch, uses rs, rt.
  - addi 0x08, addiu 0x09, slti 0x0A: sign-extended imm, dest=rt, uses rs.
  - andi 0x0C, ori 0x0D: zero-extended imm, dest=rt, uses rs.
  - lui 0x0F: imm={imm16,16'b0}, dest=rt, rs unused.
  - j 0x02: jump, no operands.
  - jal 0x03: jump, dest=LINK_REG, reg_write.
  - Any other opcode: id_illegal=1; reg_write/mem_read/mem_write/branch/jump all 0.
- Outputs are a combinational decode of the ID register. Only id_issue qualifies them.
- Dest 0 always forces id_reg_write=0.
- Flush in the same cycle as a hazard: flush wins, stall_out=0, slot becomes empty.
- Reset asserted mid-stall: slot cleared and stall_out=0 immediately.

Decomposition:
- Shared package:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_J, OP_JAL);
  - FUNCT_JR;
  - instruction field bit positions.
- Sub-module decode_ctrl: purely combinational opcode→control/imm/dest/uses_rs/uses_rt decoder. Reused by the hazard logic.

Test Plan:
- Reset, then valid_in=1 with addi r2,r1,5 (0x20220005), bank returns r1=7 → next cycle id_issue=1, id_opa=7, id_imm=5, id_dest=2, id_reg_write=1.
- EX holds lw with ex_dest=3; ID holds add r4,r3,r5 → stall_out=1 and id_issue=0 for one cycle; addra stays 3; issues the following cycle.
- Writeback enc=1, addrc=6, datac=0xDEADBEEF on the same edge ID loads an instruction reading r6 (dataa returns stale 0) → id_opa=0xDEADBEEF.
- Instruction with rs=0 while the bank returns 0x1234 and enc=1, addrc=0 → id_opa=0, no bypass.
- flush=1 during a load-use stall → stall_out=0 that cycle, id_issue=0 next cycle, the next fetch word is accepted.
- Opcode 0x3F → id_illegal=1, all write/mem/branch controls 0. jal → id_dest=31; andi with imm 0x8000 → id_imm=0x00008000.
